// File: rtl/mult_share_sched.sv
// Round-robin scheduler sharing one combinational W x W array multiplier among NREQ requesters,
// plus the array multiplier itself (AND partial products, carry-save reduction, prefix adder).
`timescale 1ns/1ps

module mult_array #(
    parameter int W = 4
) (
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    output logic [2*W-1:0] p
);
    localparam int PW = 2 * W;

    logic [PW-1:0] pp    [W];
    logic [PW-1:0] s_row [W];
    logic [PW-1:0] c_row [W];
    logic [PW-1:0] g_acc;
    logic [PW-1:0] p_acc;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_pp
            assign pp[gi] = PW'({W{y[gi]}} & x) << gi;
        end
    endgenerate

    assign s_row[0] = pp[0];
    assign c_row[0] = '0;

    // Carry-save rows: the first row has a zero carry vector, so its cells reduce to half adders.
    generate
        for (gi = 1; gi < W; gi++) begin : g_csa
            assign s_row[gi] = s_row[gi-1] ^ c_row[gi-1] ^ pp[gi];
            assign c_row[gi] = ((s_row[gi-1] & c_row[gi-1]) |
                                (s_row[gi-1] & pp[gi])      |
                                (c_row[gi-1] & pp[gi])) << 1;
        end
    endgenerate

    // Kogge-Stone carry prefix; carry-in is zero so group propagate below bit d may be cleared.
    always_comb begin
        g_acc = s_row[W-1] & c_row[W-1];
        p_acc = s_row[W-1] ^ c_row[W-1];
        for (int d = 1; d < PW; d = d * 2) begin
            g_acc = g_acc | (p_acc & (g_acc << d));
            p_acc = p_acc & (p_acc << d);
        end
        p = (s_row[W-1] ^ c_row[W-1]) ^ (g_acc << 1);
    end
endmodule

module mult_share_sched #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    parameter int CNTW = 8,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_x,
    input  logic [NREQ*W-1:0] req_y,
    output logic [W-1:0]      mul_x,
    output logic [W-1:0]      mul_y,
    input  logic [2*W-1:0]    mul_o,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [2*W-1:0]    rsp_prod,
    output logic [CNTW-1:0]   done_cnt
);
    logic [W-1:0]   op_x [NREQ];
    logic [W-1:0]   op_y [NREQ];
    logic           v1;
    logic           v2;
    logic [IDW-1:0] id1;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_next;
    logic [IDW-1:0] win;
    logic           found;
    logic           acc1;
    logic           adv2;
    logic           hs;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign op_x[gi]      = req_x[gi*W +: W];
            assign op_y[gi]      = req_y[gi*W +: W];
            assign req_ready[gi] = hs & (win == IDW'(gi));
        end
    endgenerate

    assign adv2 = v1 & (~v2 | rsp_ready);
    assign acc1 = ~v1 | adv2;
    // Gated by rst_n so no grant is offered while reset is held.
    assign hs   = rst_n & acc1 & found;

    // Scan from the farthest offset down so the nearest valid requester after ptr wins.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req_valid[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    assign ptr_next = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            id1   <= '0;
            ptr   <= '0;
            mul_x <= '0;
            mul_y <= '0;
        end else if (acc1) begin
            if (hs) begin
                v1    <= 1'b1;
                id1   <= win;
                ptr   <= ptr_next;
                mul_x <= op_x[win];
                mul_y <= op_y[win];
            end else begin
                v1 <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2       <= 1'b0;
            rsp_id   <= '0;
            rsp_prod <= '0;
        end else if (adv2) begin
            v2       <= 1'b1;
            rsp_id   <= id1;
            rsp_prod <= mul_o;
        end else if (v2 && rsp_ready) begin
            v2 <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt <= '0;
        end else if (v2 && rsp_ready) begin
            done_cnt <= done_cnt + 1'b1;
        end
    end

    assign rsp_valid = v2;
endmodule

// File: tb/tb_mult_share_sched.sv
// Directed bench for mult_share_sched driving a real array multiplier on the shared port.
`timescale 1ns/1ps

module tb_mult_share_sched;
    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int CNTW = 8;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_x;
    logic [NREQ*W-1:0] req_y;
    logic [W-1:0]      mul_x;
    logic [W-1:0]      mul_y;
    logic [2*W-1:0]    mul_o;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [2*W-1:0]    rsp_prod;
    logic [CNTW-1:0]   done_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Backpressure scenario: one row per cycle
    localparam logic [3:0] BP_VALID [10] = '{4'hF, 4'hB, 4'h3, 4'h3, 4'h3, 4'h3, 4'h2, 4'h0, 4'h0, 4'h0};
    localparam logic       BP_RDY   [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam logic [3:0] BP_GRANT [10] = '{4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h0, 4'h0, 4'h0};
    localparam logic       BP_RV    [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam logic [1:0] BP_ID    [10] = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0};
    localparam logic [7:0] BP_PROD  [10] = '{8'd0, 8'd0, 8'd28, 8'd28, 8'd28, 8'd28, 8'd35, 8'd14, 8'd21, 8'd0};

    localparam logic [7:0] RR_PROD [4] = '{8'd2, 8'd6, 8'd12, 8'd20};
    localparam logic [3:0] CX [3] = '{4'd15, 4'd0, 4'd1};
    localparam logic [3:0] CY [3] = '{4'd15, 4'd9, 4'd15};
    localparam logic [7:0] CP [3] = '{8'd225, 8'd0, 8'd15};

    mult_array #(.W(W)) u_mul (
        .x (mul_x),
        .y (mul_y),
        .p (mul_o)
    );

    mult_share_sched #(.NREQ(NREQ), .W(W), .CNTW(CNTW), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .mul_x     (mul_x),
        .mul_y     (mul_y),
        .mul_o     (mul_o),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_prod  (rsp_prod),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    task automatic set_op(input int i, input logic [W-1:0] x, input logic [W-1:0] y);
        req_x[i*W +: W] = x;
        req_y[i*W +: W] = y;
    endtask

    task automatic test_reset();
        req_valid = 4'hF;
        rsp_ready = 1'b0;
        req_x     = '0;
        req_y     = '0;
        #1 rst_n = 1'b0;
        #2;
        n_tests++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL reset_ready: got %b want %b", req_ready, 4'h0); end
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_tests++; if (done_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_done: got %0d want 0", done_cnt); end
        n_tests++; if ({mul_x, mul_y, rsp_prod} !== 16'h0) begin n_fail++; $display("FAIL reset_regs: got %h want 0", {mul_x, mul_y, rsp_prod}); end
        @(posedge clk); #1;
        rst_n     = 1'b1;
        req_valid = 4'h0;
        @(negedge clk);
        n_tests++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL reset_idle_ready: got %b want %b", req_ready, 4'h0); end
        $display("[TB] reset released");
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 4; i++) set_op(i, W'(i + 1), W'(i + 2));
        rsp_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            req_valid = (k < 6) ? 4'hF : 4'h0;
            @(negedge clk);
            n_tests++;
            if (req_ready !== ((k < 6) ? 4'(1 << (k % 4)) : 4'h0)) begin
                n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, (k < 6) ? 4'(1 << (k % 4)) : 4'h0);
            end
            if (k >= 2 && k < 8) begin
                n_tests++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'((k - 2) % 4) || rsp_prod !== RR_PROD[(k - 2) % 4]) begin
                    n_fail++; $display("FAIL rr_rsp[%0d]: got v=%b id=%0d prod=%0d want v=1 id=%0d prod=%0d",
                                       k, rsp_valid, rsp_id, rsp_prod, (k - 2) % 4, RR_PROD[(k - 2) % 4]);
                end
                $display("[TB] rr rsp id=%0d prod=%0d", rsp_id, rsp_prod);
            end else begin
                n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rr_idle[%0d]: got %b want 0", k, rsp_valid); end
            end
        end
        n_tests++; if (done_cnt !== 8'd6) begin n_fail++; $display("FAIL rr_done: got %0d want 6", done_cnt); end
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        set_op(2, 4'd3, 4'd5);
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        @(negedge clk);
        n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b want %b", req_ready, 4'b0100); end
        @(posedge clk); #1;
        req_valid = 4'h0;
        @(negedge clk);
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: got %b want 0", rsp_valid); end
        n_tests++; if (mul_x !== 4'd3 || mul_y !== 4'd5) begin n_fail++; $display("FAIL single_operands: got %0d,%0d want 3,5", mul_x, mul_y); end
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_prod !== 8'd15) begin
            n_fail++; $display("FAIL single_rsp: got v=%b id=%0d prod=%0d want v=1 id=2 prod=15", rsp_valid, rsp_id, rsp_prod);
        end
        $display("[TB] single rsp id=%0d prod=%0d", rsp_id, rsp_prod);
        @(negedge clk);
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_drop: got %b want 0", rsp_valid); end
        n_tests++; if (done_cnt !== 8'd7) begin n_fail++; $display("FAIL single_done: got %0d want 7", done_cnt); end
    endtask

    task automatic test_corners();
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (k < 3) begin
                set_op(1, CX[k], CY[k]);
                req_valid = 4'b0010;
            end else begin
                req_valid = 4'h0;
            end
            @(negedge clk);
            if (k < 3) begin
                n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL corner_ready[%0d]: got %b want %b", k, req_ready, 4'b0010); end
            end
            if (k >= 2 && k < 5) begin
                n_tests++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_prod !== CP[k - 2]) begin
                    n_fail++; $display("FAIL corner_rsp[%0d]: got v=%b id=%0d prod=%0d want v=1 id=1 prod=%0d",
                                       k, rsp_valid, rsp_id, rsp_prod, CP[k - 2]);
                end
                $display("[TB] corner rsp id=%0d prod=%0d", rsp_id, rsp_prod);
            end
        end
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL corner_idle: got %b want 0", rsp_valid); end
        n_tests++; if (done_cnt !== 8'd10) begin n_fail++; $display("FAIL corner_done: got %0d want 10", done_cnt); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) set_op(i, W'(i + 2), 4'd7);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            req_valid = BP_VALID[k];
            rsp_ready = BP_RDY[k];
            @(negedge clk);
            n_tests++; if (req_ready !== BP_GRANT[k]) begin n_fail++; $display("FAIL bp_grant[%0d]: got %b want %b", k, req_ready, BP_GRANT[k]); end
            n_tests++;
            if (rsp_valid !== BP_RV[k] || (BP_RV[k] && (rsp_id !== BP_ID[k] || rsp_prod !== BP_PROD[k]))) begin
                n_fail++; $display("FAIL bp_rsp[%0d]: got v=%b id=%0d prod=%0d want v=%b id=%0d prod=%0d",
                                   k, rsp_valid, rsp_id, rsp_prod, BP_RV[k], BP_ID[k], BP_PROD[k]);
            end
            if (BP_RV[k]) $display("[TB] bp rsp id=%0d prod=%0d ready=%b", rsp_id, rsp_prod, rsp_ready);
        end
        n_tests++; if (done_cnt !== 8'd14) begin n_fail++; $display("FAIL bp_done: got %0d want 14", done_cnt); end
    endtask

    task automatic test_fairness();
        set_op(0, 4'd2, 4'd3);
        set_op(3, 4'd4, 4'd5);
        rsp_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            req_valid = (k < 6) ? 4'b1001 : 4'h0;
            @(negedge clk);
            n_tests++;
            if (req_ready !== ((k < 6) ? ((k % 2 == 0) ? 4'b1000 : 4'b0001) : 4'h0)) begin
                n_fail++; $display("FAIL fair_grant[%0d]: got %b", k, req_ready);
            end
            if (k >= 2 && k < 8) begin
                n_tests++;
                if (rsp_valid !== 1'b1 || rsp_id !== ((k % 2 == 0) ? 2'd3 : 2'd0) ||
                    rsp_prod !== ((k % 2 == 0) ? 8'd20 : 8'd6)) begin
                    n_fail++; $display("FAIL fair_rsp[%0d]: got v=%b id=%0d prod=%0d want id=%0d",
                                       k, rsp_valid, rsp_id, rsp_prod, (k % 2 == 0) ? 3 : 0);
                end
                $display("[TB] fair rsp id=%0d prod=%0d", rsp_id, rsp_prod);
            end
        end
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL fair_idle: got %b want 0", rsp_valid); end
        n_tests++; if (done_cnt !== 8'd20) begin n_fail++; $display("FAIL fair_done: got %0d want 20", done_cnt); end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        set_op(1, 4'd6, 4'd7);
        req_valid = 4'b0010;
        @(negedge clk);
        n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rmid_grant1: got %b want %b", req_ready, 4'b0010); end
        @(posedge clk); #1;
        set_op(2, 4'd2, 4'd2);
        req_valid = 4'b0100;
        @(negedge clk);
        n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL rmid_grant2: got %b want %b", req_ready, 4'b0100); end
        @(posedge clk); #1;
        req_valid = 4'h0;
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_prod !== 8'd42) begin
            n_fail++; $display("FAIL rmid_pre: got v=%b id=%0d prod=%0d want v=1 id=1 prod=42", rsp_valid, rsp_id, rsp_prod);
        end
        #1;
        rst_n     = 1'b0;
        req_valid = 4'hF;
        #1;
        n_tests++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL rmid_ready: got %b want 0", req_ready); end
        n_tests++;
        if ({rsp_valid, rsp_id, rsp_prod, mul_x, mul_y, done_cnt} !== 27'h0) begin
            n_fail++; $display("FAIL rmid_clear: got v=%b id=%0d prod=%0d mx=%0d my=%0d cnt=%0d want all 0",
                               rsp_valid, rsp_id, rsp_prod, mul_x, mul_y, done_cnt);
        end
        @(posedge clk); #1;
        rst_n     = 1'b1;
        req_valid = 4'h0;
        @(negedge clk);
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_stale: got %b want 0", rsp_valid); end
        @(posedge clk); #1;
        set_op(0, 4'd3, 4'd3);
        req_valid = 4'hF;
        @(negedge clk);
        n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rmid_ptr0: got %b want %b", req_ready, 4'b0001); end
        @(posedge clk); #1;
        req_valid = 4'h0;
        @(negedge clk);
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_stale2: got %b want 0", rsp_valid); end
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_prod !== 8'd9) begin
            n_fail++; $display("FAIL rmid_rsp: got v=%b id=%0d prod=%0d want v=1 id=0 prod=9", rsp_valid, rsp_id, rsp_prod);
        end
        $display("[TB] post-reset rsp id=%0d prod=%0d", rsp_id, rsp_prod);
        @(negedge clk);
        n_tests++; if (done_cnt !== 8'd1) begin n_fail++; $display("FAIL rmid_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_done_wrap();
        set_op(0, 4'd1, 4'd1);
        rsp_ready = 1'b1;
        for (int k = 0; k < 258; k++) begin
            @(posedge clk); #1;
            req_valid = (k < 255) ? 4'b0001 : 4'h0;
            @(negedge clk);
            if (k == 256) begin
                n_tests++; if (done_cnt !== 8'd255) begin n_fail++; $display("FAIL wrap_top: got %0d want 255", done_cnt); end
            end
        end
        n_tests++; if (done_cnt !== 8'd0) begin n_fail++; $display("FAIL wrap_zero: got %0d want 0", done_cnt); end
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_idle: got %b want 0", rsp_valid); end
        $display("[TB] done_cnt wrap observed value=%0d", done_cnt);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_corners();
        test_backpressure();
        test_fairness();
        test_reset_mid();
        test_done_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
